// File: rtl/prefix_tree_pipe.sv
// Pipelined Kogge-Stone prefix tree: bitwise generate/propagate, then log2(N) prefix levels,
// each followed by a register stage, with per-stage valid/enable backpressure.
module prefix_tree_pipe #(
    parameter int unsigned N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         Cin_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] G,
    output logic [N-1:0] P,
    output logic [N-1:0] Go_00,
    output logic [N-1:0] Po_00,
    output logic         Cin
);

    localparam int unsigned L = $clog2(N);
    localparam logic [N-1:0] ONES = '1;

    // Stage k registers: original G/P/Cin travel alongside the level-k group terms.
    logic [N-1:0] g_q  [L+1];
    logic [N-1:0] p_q  [L+1];
    logic [N-1:0] gk_q [L+1];
    logic [N-1:0] pk_q [L+1];
    logic [L:0]   cin_q;
    logic [L:0]   v_q;

    logic [N-1:0] gn_d [L+1];
    logic [N-1:0] pn_d [L+1];
    logic [L:0]   en_c;

    // Stage k may load unless it and every stage downstream are full and the sink stalls.
    for (genvar k = 0; k <= L; k++) begin : g_en
        assign en_c[k] = out_ready | ~(&v_q[L:k]);
    end

    // Prefix level k at distance 2^(k-1); low bits pass through (G shifts in 0, P shifts in 1).
    always_comb begin
        for (int unsigned k = 0; k <= L; k++) begin
            gn_d[k] = '0;
            pn_d[k] = '0;
        end
        for (int unsigned k = 1; k <= L; k++) begin
            gn_d[k] = gk_q[k-1] | (pk_q[k-1] & (gk_q[k-1] << (1 << (k-1))));
            pn_d[k] = pk_q[k-1] & ((pk_q[k-1] << (1 << (k-1))) | (ONES >> (N - (1 << (k-1)))));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned k = 0; k <= L; k++) begin
                g_q[k]  <= '0;
                p_q[k]  <= '0;
                gk_q[k] <= '0;
                pk_q[k] <= '0;
            end
            cin_q <= '0;
            v_q   <= '0;
        end else begin
            if (en_c[0]) begin
                g_q[0]   <= A & B;
                p_q[0]   <= A ^ B;
                gk_q[0]  <= A & B;
                pk_q[0]  <= A ^ B;
                cin_q[0] <= Cin_in;
                v_q[0]   <= in_valid;
            end
            for (int unsigned k = 1; k <= L; k++) begin
                if (en_c[k]) begin
                    g_q[k]   <= g_q[k-1];
                    p_q[k]   <= p_q[k-1];
                    gk_q[k]  <= gn_d[k];
                    pk_q[k]  <= pn_d[k];
                    cin_q[k] <= cin_q[k-1];
                    v_q[k]   <= v_q[k-1];
                end
            end
        end
    end

    assign in_ready  = en_c[0];
    assign out_valid = v_q[L];
    assign G         = g_q[L];
    assign P         = p_q[L];
    assign Go_00     = gk_q[L];
    assign Po_00     = pk_q[L];
    assign Cin       = cin_q[L];

endmodule

// File: tb/tb_prefix_tree_pipe.sv
// Bench for prefix_tree_pipe (N=32): directed vector table, streaming scoreboard with a
// ripple group-prefix model, backpressure, reset flush and random traffic.
module tb_prefix_tree_pipe;

    localparam int unsigned N = 32;
    localparam int unsigned LAT = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  A;
    logic [N-1:0]  B;
    logic          Cin_in;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  G;
    logic [N-1:0]  P;
    logic [N-1:0]  Go_00;
    logic [N-1:0]  Po_00;
    logic          Cin;

    prefix_tree_pipe #(.N(N)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .Cin_in(Cin_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .G(G), .P(P), .Go_00(Go_00), .Po_00(Po_00), .Cin(Cin)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic         cin;
        logic [N-1:0] g;
        logic [N-1:0] p;
        logic [N-1:0] go;
        logic [N-1:0] po;
    } vec_t;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    // Ripple group-prefix reference, deliberately different in form from the tree.
    function automatic vec_t model(input logic [N-1:0] a, input logic [N-1:0] b, input logic cin);
        vec_t r;
        r.a = a; r.b = b; r.cin = cin;
        r.g = a & b;
        r.p = a ^ b;
        r.go[0] = r.g[0];
        r.po[0] = r.p[0];
        for (int i = 1; i < int'(N); i++) begin
            r.go[i] = r.g[i] | (r.p[i] & r.go[i-1]);
            r.po[i] = r.p[i] & r.po[i-1];
        end
        return r;
    endfunction

    vec_t         sb_q[$];
    logic         prev_stall = 1'b0;
    logic [N-1:0] hold_g, hold_p, hold_go, hold_po;
    logic         hold_cin;

    // Transfer monitor: sees pre-edge values at each rising edge.
    always @(posedge clk) begin
        vec_t         e;
        logic [N-1:0] c;
        logic [N-1:0] sum;
        if (rst === 1'b1) begin
            sb_q.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_hold", {G, P}, {hold_g, hold_p});
                chk("stall_hold_grp", {Go_00, Po_00, 31'd0, Cin}, {hold_go, hold_po, 31'd0, hold_cin});
            end
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                if (sb_q.size() == 0) begin
                    chk("spurious_beat", 64'd1, 64'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk("sb_gp", {G, P}, {e.g, e.p});
                    chk("sb_grp", {Go_00, Po_00}, {e.go, e.po});
                    chk("sb_cin", 64'(Cin), 64'(e.cin));
                    c   = Go_00 | (Po_00 & {N{Cin}});
                    sum = P ^ {c[N-2:0], Cin};
                    chk("sb_sum", 64'({c[N-1], sum}), 64'(33'(e.a) + 33'(e.b) + 33'(e.cin)));
                end
            end
            if (in_valid === 1'b1 && in_ready === 1'b1)
                sb_q.push_back(model(A, B, Cin_in));
            prev_stall = (out_valid === 1'b1) && (out_ready === 1'b0);
            hold_g = G; hold_p = P; hold_go = Go_00; hold_po = Po_00; hold_cin = Cin;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[7];
    int   lat;
    int   acc;
    int   first_o, last_o, n_o;
    logic seen;

    initial begin
        vecs[0] = '{a:32'hFFFFFFFF, b:32'h00000001, cin:1'b0, g:32'h00000001, p:32'hFFFFFFFE, go:32'hFFFFFFFF, po:32'h00000000};
        vecs[1] = '{a:32'h00000000, b:32'hFFFFFFFF, cin:1'b1, g:32'h00000000, p:32'hFFFFFFFF, go:32'h00000000, po:32'hFFFFFFFF};
        vecs[2] = '{a:32'h00000000, b:32'h00000000, cin:1'b0, g:32'h00000000, p:32'h00000000, go:32'h00000000, po:32'h00000000};
        vecs[3] = '{a:32'hFFFFFFFF, b:32'hFFFFFFFF, cin:1'b0, g:32'hFFFFFFFF, p:32'h00000000, go:32'hFFFFFFFF, po:32'h00000000};
        vecs[4] = '{a:32'h0000000F, b:32'h00000001, cin:1'b0, g:32'h00000001, p:32'h0000000E, go:32'h0000000F, po:32'h00000000};
        vecs[5] = '{a:32'h80000000, b:32'h80000000, cin:1'b1, g:32'h80000000, p:32'h00000000, go:32'h80000000, po:32'h00000000};
        vecs[6] = '{a:32'hAAAAAAAA, b:32'h55555555, cin:1'b0, g:32'h00000000, p:32'hFFFFFFFF, go:32'h00000000, po:32'hFFFFFFFF};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0; Cin_in = 1'b0;
        step(); step();
        rst = 1'b0;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_data", {Go_00, Po_00}, 64'd0);
        chk("rst_gp", {G, P}, 64'd0);

        // Directed table: single beat each, latency and output values.
        for (int i = 0; i < 7; i++) begin
            A = vecs[i].a; B = vecs[i].b; Cin_in = vecs[i].cin;
            in_valid = 1'b1; out_ready = 1'b1;
            step();
            in_valid = 1'b0;
            lat = 1;
            while (out_valid !== 1'b1 && lat < 20) begin
                step();
                lat++;
            end
            chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(LAT));
            chk($sformatf("vec%0d_G", i), 64'(G), 64'(vecs[i].g));
            chk($sformatf("vec%0d_P", i), 64'(P), 64'(vecs[i].p));
            chk($sformatf("vec%0d_Go", i), 64'(Go_00), 64'(vecs[i].go));
            chk($sformatf("vec%0d_Po", i), 64'(Po_00), 64'(vecs[i].po));
            chk($sformatf("vec%0d_Cin", i), 64'(Cin), 64'(vecs[i].cin));
            step();
        end

        // Back-to-back: 20 beats, results on consecutive cycles.
        first_o = -1; last_o = -1; n_o = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 30; i++) begin
            in_valid = (i < 20);
            A = $urandom; B = $urandom; Cin_in = 1'($urandom);
            #1;
            if (i < 20) chk("b2b_in_ready", 64'(in_ready), 64'd1);
            step();
            if (out_valid === 1'b1) begin
                if (first_o < 0) first_o = i;
                last_o = i;
                n_o++;
            end
        end
        chk("b2b_count", 64'(n_o), 64'd20);
        chk("b2b_span", 64'(last_o - first_o), 64'd19);

        // Backpressure: pipe holds exactly L+1 beats.
        acc = 0;
        out_ready = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            A = $urandom; B = $urandom; Cin_in = 1'($urandom);
            #1;
            if (in_ready === 1'b1) acc++;
            step();
        end
        chk("bp_accepted", 64'(acc), 64'(LAT));
        chk("bp_in_ready_low", 64'(in_ready), 64'd0);
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 20 && sb_q.size() != 0; i++) step();
        chk("bp_drained", 64'(sb_q.size()), 64'd0);

        // Reset with three beats in flight.
        out_ready = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            A = $urandom | 32'h1; B = $urandom | 32'h1; Cin_in = 1'b1;
            step();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_gp", {G, P}, 64'd0);
        chk("mid_rst_grp", {Go_00, Po_00}, 64'd0);
        chk("mid_rst_cin", 64'(Cin), 64'd0);
        chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        chk("no_stale_beat", 64'(seen), 64'd0);

        // Random traffic with random backpressure, checked by the monitor.
        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom_range(9) < 7);
            out_ready = ($urandom_range(9) < 6);
            case ($urandom_range(7))
                0:       begin A = '1; B = $urandom; end
                1:       begin A = $urandom; B = ~A; end
                default: begin A = $urandom; B = $urandom; end
            endcase
            Cin_in = 1'($urandom);
            step();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 20 && sb_q.size() != 0; i++) step();
        chk("final_drained", 64'(sb_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
